// File: rtl/reg_lane_bank_if.sv
// Bus bundle for reg_lane_bank: request strobes, load/shift data and the
// registered outputs. The slave modport is the register bank; the master
// modport is the round logic or key path that drives it.
interface reg_lane_bank_if #(
    parameter int LANES  = 10,
    parameter int LANE_W = 8
) ();
    localparam int FILL_W = $clog2(LANES + 1);

    logic                      CLR;
    logic                      LOAD;
    logic [LANES-1:0]          LANE_EN;
    logic                      SHIFT;
    logic                      ROTATE;
    logic [LANES*LANE_W-1:0]   reg_now;
    logic [LANE_W-1:0]         lane_in;
    logic [LANES*LANE_W-1:0]   reg_next;
    logic [FILL_W-1:0]         fill;
    logic                      full;

    modport slave (
        input  CLR, LOAD, LANE_EN, SHIFT, ROTATE, reg_now, lane_in,
        output reg_next, fill, full
    );

    modport master (
        output CLR, LOAD, LANE_EN, SHIFT, ROTATE, reg_now, lane_in,
        input  reg_next, fill, full
    );
endinterface

// File: rtl/reg_lane_bank.sv
// Lane-structured state register: LANES lanes of LANE_W bits with masked
// parallel load, serial lane shift-in with a saturating fill counter,
// lane rotation toward the MSB and synchronous clear.
// One operation per cycle, priority CLR > LOAD > SHIFT > ROTATE > hold.
module reg_lane_bank #(
    parameter int LANES     = 10,
    parameter int LANE_W    = 8,
    parameter int ROT_LANES = 1
) (
    input  logic            CLK,
    input  logic            RESET,
    reg_lane_bank_if.slave  bus
);
    localparam int FILL_W = $clog2(LANES + 1);
    localparam int DATA_W = LANES * LANE_W;

    logic [DATA_W-1:0] r_data;
    logic [FILL_W-1:0] r_fill;

    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_shift_data;
    logic [DATA_W-1:0] w_rot_data;
    logic [DATA_W-1:0] w_data_next;
    logic [FILL_W-1:0] w_fill_inc;
    logic [FILL_W-1:0] w_fill_next;
    logic              w_full;

    // Per-lane candidate values for each operation; the priority mux below
    // picks one of them.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            // Source lane for rotation: lane gi receives lane gi-ROT_LANES (mod LANES).
            localparam int SRC_ROT = (gi + LANES - ROT_LANES) % LANES;

            assign w_load_data[gi*LANE_W +: LANE_W] = bus.LANE_EN[gi]
                ? bus.reg_now[gi*LANE_W +: LANE_W]
                : r_data[gi*LANE_W +: LANE_W];

            if (gi == 0) begin : g_shift_head
                assign w_shift_data[0 +: LANE_W] = bus.lane_in;
            end else begin : g_shift_body
                assign w_shift_data[gi*LANE_W +: LANE_W] = r_data[(gi-1)*LANE_W +: LANE_W];
            end

            assign w_rot_data[gi*LANE_W +: LANE_W] = r_data[SRC_ROT*LANE_W +: LANE_W];
        end
    endgenerate

    // full depends only on the fill register, never on the request inputs.
    assign w_full     = (r_fill == FILL_W'(LANES));
    // Fill saturates at LANES so extra shifts while full keep it pinned.
    assign w_fill_inc = w_full ? r_fill : r_fill + FILL_W'(1);

    // Priority selection of next data and fill; a LOAD with no lanes enabled
    // still wins arbitration and therefore blocks SHIFT/ROTATE.
    always_comb begin
        w_data_next = r_data;
        w_fill_next = r_fill;
        if (bus.CLR) begin
            w_data_next = '0;
            w_fill_next = '0;
        end else if (bus.LOAD) begin
            w_data_next = w_load_data;
            if (&bus.LANE_EN) begin
                w_fill_next = FILL_W'(LANES);
            end
        end else if (bus.SHIFT) begin
            w_data_next = w_shift_data;
            w_fill_next = w_fill_inc;
        end else if (bus.ROTATE) begin
            w_data_next = w_rot_data;
        end
    end

    // State registers with asynchronous clear on RESET.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_data <= '0;
            r_fill <= '0;
        end else begin
            r_data <= w_data_next;
            r_fill <= w_fill_next;
        end
    end

    assign bus.reg_next = r_data;
    assign bus.fill     = r_fill;
    assign bus.full     = w_full;
endmodule
